// File: rtl/alu_16_driver.sv
// -----------------------------------------------------------------------------
// alu_16_driver
//
// Command-side driver for an external combinational 4-op ALU. A command is
// taken on the cmd valid/ready port. Its operands and op-select are registered
// onto the ALU inputs. The driver then waits SETTLE_CYCLES clock edges for the
// ALU output to settle. It captures the result, optionally writes it into the
// accumulator, and holds it on the rsp valid/ready port until it is consumed.
//
// Parameters
//   WIDTH          operand/result width (must match the attached ALU)
//   SETTLE_CYCLES  edges allowed for ALU settling before capture (>= 1)
//
// Ports
//   clk, rst_n                 clock; asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only while idle)
//   cmd_op                     00 add, 01 sub, 10 and, 11 or
//   cmd_a, cmd_b               operands (cmd_a ignored when cmd_use_acc=1)
//   cmd_use_acc                take operand A from the accumulator
//   cmd_acc_wr                 write the captured result into the accumulator
//   alu_a, alu_b, alu_op0/1    registered drive to the ALU
//   alu_y                      ALU result
//   rsp_valid/rsp_ready        response handshake
//   rsp_y, rsp_zero            captured result and its zero flag
//   acc_q                      accumulator value
// -----------------------------------------------------------------------------
module alu_16_driver #(
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_use_acc,
    input  logic             cmd_acc_wr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_op0,
    output logic             alu_op1,
    input  logic [WIDTH-1:0] alu_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] acc_q
);

    generate
        if (SETTLE_CYCLES < 1) begin : g_settle_check
            $error("alu_16_driver: SETTLE_CYCLES must be at least 1");
        end
    endgenerate

    // The counter only has to hold SETTLE_CYCLES-1, down to 0.
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t           state_reg,    state_next;
    logic [CNT_W-1:0] cnt_reg,      cnt_next;
    logic             acc_wr_reg,   acc_wr_next;
    logic [WIDTH-1:0] alu_a_reg,    alu_a_next;
    logic [WIDTH-1:0] alu_b_reg,    alu_b_next;
    logic [1:0]       alu_op_reg,   alu_op_next;
    logic [WIDTH-1:0] rsp_y_reg,    rsp_y_next;
    logic             rsp_zero_reg, rsp_zero_next;
    logic [WIDTH-1:0] acc_reg,      acc_next;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            acc_wr_reg   <= 1'b0;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            alu_op_reg   <= 2'b00;
            rsp_y_reg    <= '0;
            rsp_zero_reg <= 1'b0;
            acc_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            acc_wr_reg   <= acc_wr_next;
            alu_a_reg    <= alu_a_next;
            alu_b_reg    <= alu_b_next;
            alu_op_reg   <= alu_op_next;
            rsp_y_reg    <= rsp_y_next;
            rsp_zero_reg <= rsp_zero_next;
            acc_reg      <= acc_next;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        acc_wr_next   = acc_wr_reg;
        alu_a_next    = alu_a_reg;
        alu_b_next    = alu_b_reg;
        alu_op_next   = alu_op_reg;
        rsp_y_next    = rsp_y_reg;
        rsp_zero_next = rsp_zero_reg;
        acc_next      = acc_reg;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    // The accumulator is read as it stands now. A write-back
                    // from the previous command is therefore already included.
                    alu_a_next  = cmd_use_acc ? acc_reg : cmd_a;
                    alu_b_next  = cmd_b;
                    alu_op_next = cmd_op;
                    acc_wr_next = cmd_acc_wr;
                    cnt_next    = CNT_LOAD;
                    state_next  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    rsp_y_next    = alu_y;
                    rsp_zero_next = (alu_y == '0);
                    if (acc_wr_reg) begin
                        acc_next = alu_y;
                    end
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                // No bypass to a new command: IDLE must be visited first.
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_reg == ST_IDLE);
    assign rsp_valid = (state_reg == ST_RESP);
    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_op0   = alu_op_reg[0];
    assign alu_op1   = alu_op_reg[1];
    assign rsp_y     = rsp_y_reg;
    assign rsp_zero  = rsp_zero_reg;
    assign acc_q     = acc_reg;

endmodule

// File: tb/tb_alu_16_driver.sv
// -----------------------------------------------------------------------------
// tb_alu_16_driver
//
// Two driver instances: d1 uses SETTLE_CYCLES=1 and d4 uses SETTLE_CYCLES=4.
// Each has a behavioural ALU attached. Expected results come from a reference
// model of the op rules and of the accumulator that the bench keeps itself.
// -----------------------------------------------------------------------------
module tb_alu_16_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // d1 signals
    logic        d1_cmd_valid = 1'b0, d1_cmd_ready;
    logic [1:0]  d1_cmd_op = 2'b00;
    logic [15:0] d1_cmd_a = '0, d1_cmd_b = '0;
    logic        d1_cmd_use_acc = 1'b0, d1_cmd_acc_wr = 1'b0;
    logic [15:0] d1_alu_a, d1_alu_b, d1_alu_y;
    logic        d1_alu_op0, d1_alu_op1;
    logic        d1_rsp_valid, d1_rsp_ready = 1'b0, d1_rsp_zero;
    logic [15:0] d1_rsp_y, d1_acc_q;

    // d4 signals
    logic        d4_cmd_valid = 1'b0, d4_cmd_ready;
    logic [1:0]  d4_cmd_op = 2'b00;
    logic [15:0] d4_cmd_a = '0, d4_cmd_b = '0;
    logic        d4_cmd_use_acc = 1'b0, d4_cmd_acc_wr = 1'b0;
    logic [15:0] d4_alu_a, d4_alu_b, d4_alu_y;
    logic        d4_alu_op0, d4_alu_op1;
    logic        d4_rsp_valid, d4_rsp_ready = 1'b0, d4_rsp_zero;
    logic [15:0] d4_rsp_y, d4_acc_q;

    int n_pass = 0;
    int n_total = 0;

    // Behavioural combinational ALU, as wired to the driver.
    function automatic logic [15:0] alu_model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a + ~b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    // Reference result from the op rules (sub is a-b-1 because carry-in is 0).
    function automatic logic [15:0] ref_result(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b - 16'd1;
            2'b10:   r = a & b;
            default: r = a | b;
        endcase
        return r;
    endfunction

    assign d1_alu_y = alu_model({d1_alu_op1, d1_alu_op0}, d1_alu_a, d1_alu_b);
    assign d4_alu_y = alu_model({d4_alu_op1, d4_alu_op0}, d4_alu_a, d4_alu_b);

    alu_16_driver #(.WIDTH(16), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(d1_cmd_valid), .cmd_ready(d1_cmd_ready), .cmd_op(d1_cmd_op),
        .cmd_a(d1_cmd_a), .cmd_b(d1_cmd_b), .cmd_use_acc(d1_cmd_use_acc), .cmd_acc_wr(d1_cmd_acc_wr),
        .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_op0(d1_alu_op0), .alu_op1(d1_alu_op1), .alu_y(d1_alu_y),
        .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready), .rsp_y(d1_rsp_y), .rsp_zero(d1_rsp_zero),
        .acc_q(d1_acc_q)
    );

    alu_16_driver #(.WIDTH(16), .SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(d4_cmd_valid), .cmd_ready(d4_cmd_ready), .cmd_op(d4_cmd_op),
        .cmd_a(d4_cmd_a), .cmd_b(d4_cmd_b), .cmd_use_acc(d4_cmd_use_acc), .cmd_acc_wr(d4_cmd_acc_wr),
        .alu_a(d4_alu_a), .alu_b(d4_alu_b), .alu_op0(d4_alu_op0), .alu_op1(d4_alu_op1), .alu_y(d4_alu_y),
        .rsp_valid(d4_rsp_valid), .rsp_ready(d4_rsp_ready), .rsp_y(d4_rsp_y), .rsp_zero(d4_rsp_zero),
        .acc_q(d4_acc_q)
    );

    // Reference model state for d1.
    logic [15:0] m_acc = '0;
    logic [15:0] exp_a, exp_y;

    // Observations recorded by run_cmd for the calling test to compare.
    logic [15:0] obs_alu_a, obs_alu_b, obs_y, obs_acc;
    logic [1:0]  obs_op;
    logic        obs_zero, obs_valid_after, obs_ready_after;
    int          obs_lat;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Updates the reference model for one d1 command.
    task automatic model_cmd(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                             input logic ua, input logic aw);
        exp_a = ua ? m_acc : a;
        exp_y = ref_result(op, exp_a, b);
        if (aw) m_acc = exp_y;
    endtask

    // Drives one d1 command to completion and records what the DUT showed.
    task automatic run_cmd(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic ua, input logic aw, input int hold);
        int guard;
        d1_cmd_op = op; d1_cmd_a = a; d1_cmd_b = b;
        d1_cmd_use_acc = ua; d1_cmd_acc_wr = aw; d1_cmd_valid = 1'b1;
        guard = 0;
        while (d1_cmd_ready !== 1'b1 && guard < 20) begin step(); guard++; end
        step();
        d1_cmd_valid = 1'b0;
        obs_alu_a = d1_alu_a; obs_alu_b = d1_alu_b; obs_op = {d1_alu_op1, d1_alu_op0};
        obs_lat = 0;
        while (d1_rsp_valid !== 1'b1 && obs_lat < 20) begin step(); obs_lat++; end
        if (guard >= 20) obs_lat = -1;
        obs_y = d1_rsp_y; obs_zero = d1_rsp_zero; obs_acc = d1_acc_q;
        repeat (hold) step();
        d1_rsp_ready = 1'b1;
        step();
        d1_rsp_ready = 1'b0;
        obs_valid_after = d1_rsp_valid;
        obs_ready_after = d1_cmd_ready;
        $display("txn op=%0d a=%h b=%h ua=%0b aw=%0b -> y=%h zero=%0b acc=%h lat=%0d",
                 op, a, b, ua, aw, obs_y, obs_zero, obs_acc, obs_lat);
    endtask

    task automatic test_reset();
        step(); step();
        #3 rst_n = 1'b0;
        #1;
        n_total++;
        if (d1_rsp_valid !== 1'b0) $display("FAIL reset_async_rsp_valid got=%b exp=0", d1_rsp_valid);
        else n_pass++;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        step();
        n_total++;
        if (d1_cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got=%b exp=1", d1_cmd_ready); else n_pass++;
        n_total++;
        if (d1_rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", d1_rsp_valid); else n_pass++;
        n_total++;
        if (d1_acc_q !== 16'h0) $display("FAIL reset_acc_q got=%h exp=0000", d1_acc_q); else n_pass++;
        n_total++;
        if ({d1_alu_a, d1_alu_b} !== 32'h0) $display("FAIL reset_alu_ab got=%h/%h exp=0000/0000", d1_alu_a, d1_alu_b);
        else n_pass++;
        n_total++;
        if ({d1_alu_op1, d1_alu_op0} !== 2'b00) $display("FAIL reset_alu_op got=%b exp=00", {d1_alu_op1, d1_alu_op0});
        else n_pass++;
        n_total++;
        if ({d1_rsp_y, d1_rsp_zero} !== 17'h0) $display("FAIL reset_rsp_y got=%h z=%b exp=0000 z=0", d1_rsp_y, d1_rsp_zero);
        else n_pass++;
        n_total++;
        if (d4_cmd_ready !== 1'b1 || d4_rsp_valid !== 1'b0)
            $display("FAIL reset_d4 got ready=%b valid=%b exp ready=1 valid=0", d4_cmd_ready, d4_rsp_valid);
        else n_pass++;
        m_acc = '0;
    endtask

    task automatic test_add();
        model_cmd(2'b00, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
        run_cmd(2'b00, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
        n_total++;
        if (obs_alu_a !== 16'h1234 || obs_alu_b !== 16'h0FFF || obs_op !== 2'b00)
            $display("FAIL add_alu_drive got=%h/%h/%b exp=1234/0fff/00", obs_alu_a, obs_alu_b, obs_op);
        else n_pass++;
        n_total++;
        if (obs_lat !== 1) $display("FAIL add_latency got=%0d exp=1", obs_lat); else n_pass++;
        n_total++;
        if (obs_y !== 16'h2233 || obs_y !== exp_y) $display("FAIL add_result got=%h exp=2233", obs_y); else n_pass++;
        n_total++;
        if (obs_zero !== 1'b0) $display("FAIL add_zero got=%b exp=0", obs_zero); else n_pass++;
        n_total++;
        if (obs_valid_after !== 1'b0 || obs_ready_after !== 1'b1)
            $display("FAIL add_handshake_idle got valid=%b ready=%b exp 0/1", obs_valid_after, obs_ready_after);
        else n_pass++;
    endtask

    task automatic test_sub();
        model_cmd(2'b01, 16'h0005, 16'h0005, 1'b0, 1'b0);
        run_cmd(2'b01, 16'h0005, 16'h0005, 1'b0, 1'b0, 1);
        n_total++;
        if (obs_y !== 16'hFFFF || obs_zero !== 1'b0)
            $display("FAIL sub_equal got=%h z=%b exp=ffff z=0", obs_y, obs_zero);
        else n_pass++;
        model_cmd(2'b01, 16'h0000, 16'hFFFF, 1'b0, 1'b0);
        run_cmd(2'b01, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 0);
        n_total++;
        if (obs_y !== 16'h0000 || obs_zero !== 1'b1)
            $display("FAIL sub_zero got=%h z=%b exp=0000 z=1", obs_y, obs_zero);
        else n_pass++;
        n_total++;
        if (obs_op !== 2'b01) $display("FAIL sub_alu_op got=%b exp=01", obs_op); else n_pass++;
    endtask

    task automatic test_acc_chain();
        logic [1:0]  ops  [4] = '{2'b00, 2'b00, 2'b10, 2'b11};
        logic [15:0] bs   [4] = '{16'h8000, 16'h8000, 16'h00FF, 16'h00F0};
        logic [15:0] accs [4] = '{16'h8000, 16'h0000, 16'h0000, 16'h00F0};
        for (int i = 0; i < 4; i++) begin
            model_cmd(ops[i], 16'hDEAD, bs[i], 1'b1, 1'b1);
            run_cmd(ops[i], 16'hDEAD, bs[i], 1'b1, 1'b1, 0);
            n_total++;
            if (obs_acc !== accs[i] || obs_acc !== m_acc)
                $display("FAIL acc_chain_%0d got=%h exp=%h", i, obs_acc, accs[i]);
            else n_pass++;
            n_total++;
            if (obs_alu_a !== exp_a) $display("FAIL acc_chain_opa_%0d got=%h exp=%h", i, obs_alu_a, exp_a);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int guard;
        d1_cmd_op = 2'b11; d1_cmd_a = 16'h00AA; d1_cmd_b = 16'h0055;
        d1_cmd_use_acc = 1'b0; d1_cmd_acc_wr = 1'b0; d1_cmd_valid = 1'b1;
        step();
        // A second command stays presented throughout the stall.
        d1_cmd_op = 2'b00; d1_cmd_a = 16'h0100; d1_cmd_b = 16'h0001;
        step();
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (d1_rsp_valid !== 1'b1 || d1_rsp_y !== 16'h00FF || d1_alu_a !== 16'h00AA ||
                d1_alu_b !== 16'h0055 || {d1_alu_op1, d1_alu_op0} !== 2'b11 || d1_cmd_ready !== 1'b0)
                $display("FAIL bp_hold_%0d got v=%b y=%h a=%h b=%h op=%b rdy=%b exp v=1 y=00ff a=00aa b=0055 op=11 rdy=0",
                         i, d1_rsp_valid, d1_rsp_y, d1_alu_a, d1_alu_b, {d1_alu_op1, d1_alu_op0}, d1_cmd_ready);
            else n_pass++;
            step();
        end
        d1_rsp_ready = 1'b1;
        step();
        d1_rsp_ready = 1'b0;
        n_total++;
        if (d1_rsp_valid !== 1'b0 || d1_cmd_ready !== 1'b1 || d1_alu_a !== 16'h00AA)
            $display("FAIL bp_release got v=%b rdy=%b a=%h exp v=0 rdy=1 a=00aa", d1_rsp_valid, d1_cmd_ready, d1_alu_a);
        else n_pass++;
        step();
        d1_cmd_valid = 1'b0;
        n_total++;
        if (d1_alu_a !== 16'h0100 || d1_alu_b !== 16'h0001)
            $display("FAIL bp_next_accept got=%h/%h exp=0100/0001", d1_alu_a, d1_alu_b);
        else n_pass++;
        guard = 0;
        while (d1_rsp_valid !== 1'b1 && guard < 20) begin step(); guard++; end
        n_total++;
        if (d1_rsp_y !== ref_result(2'b00, 16'h0100, 16'h0001) || guard !== 1)
            $display("FAIL bp_next_result got=%h lat=%0d exp=0101 lat=1", d1_rsp_y, guard);
        else n_pass++;
        $display("txn backpressure next y=%h", d1_rsp_y);
        d1_rsp_ready = 1'b1;
        step();
        d1_rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [15:0] a, b;
        logic        ua, aw;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 16'($urandom);
            b  = 16'($urandom);
            ua = 1'($urandom_range(0, 1));
            aw = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                op = 2'b10;
                b  = ~(ua ? m_acc : a);
            end
            model_cmd(op, a, b, ua, aw);
            run_cmd(op, a, b, ua, aw, int'($urandom_range(0, 3)));
            n_total++;
            if (obs_alu_a !== exp_a || obs_alu_b !== b || obs_op !== op)
                $display("FAIL rand_drive_%0d got=%h/%h/%b exp=%h/%h/%b", i, obs_alu_a, obs_alu_b, obs_op, exp_a, b, op);
            else n_pass++;
            n_total++;
            if (obs_y !== exp_y || obs_zero !== (exp_y == 16'h0))
                $display("FAIL rand_result_%0d got=%h z=%b exp=%h z=%b", i, obs_y, obs_zero, exp_y, exp_y == 16'h0);
            else n_pass++;
            n_total++;
            if (obs_acc !== m_acc || obs_lat !== 1)
                $display("FAIL rand_acc_lat_%0d got acc=%h lat=%0d exp acc=%h lat=1", i, obs_acc, obs_lat, m_acc);
            else n_pass++;
        end
    endtask

    task automatic test_settle4();
        int lat;
        int seen;
        d4_cmd_op = 2'b00; d4_cmd_a = 16'h0003; d4_cmd_b = 16'h0004;
        d4_cmd_use_acc = 1'b0; d4_cmd_acc_wr = 1'b1; d4_cmd_valid = 1'b1;
        step();
        d4_cmd_valid = 1'b0;
        lat = 0;
        while (d4_rsp_valid !== 1'b1 && lat < 20) begin step(); lat++; end
        $display("txn d4 op=0 a=0003 b=0004 -> y=%h acc=%h lat=%0d", d4_rsp_y, d4_acc_q, lat);
        n_total++;
        if (lat !== 4) $display("FAIL s4_latency got=%0d exp=4", lat); else n_pass++;
        n_total++;
        if (d4_rsp_y !== ref_result(2'b00, 16'h0003, 16'h0004) || d4_acc_q !== 16'h0007)
            $display("FAIL s4_result got y=%h acc=%h exp y=0007 acc=0007", d4_rsp_y, d4_acc_q);
        else n_pass++;
        d4_rsp_ready = 1'b1;
        step();
        d4_rsp_ready = 1'b0;

        // Second command is abandoned by reset at the second edge after accept.
        d4_cmd_use_acc = 1'b1; d4_cmd_b = 16'h0010; d4_cmd_valid = 1'b1;
        step();
        d4_cmd_valid = 1'b0;
        n_total++;
        if (d4_alu_a !== 16'h0007) $display("FAIL s4_acc_operand got=%h exp=0007", d4_alu_a); else n_pass++;
        step();
        #3 rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        m_acc = '0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (d4_rsp_valid === 1'b1) seen++;
        end
        $display("txn d4 reset mid-settle -> valid_seen=%0d acc=%h ready=%b", seen, d4_acc_q, d4_cmd_ready);
        n_total++;
        if (seen !== 0) $display("FAIL s4_reset_no_rsp got=%0d exp=0", seen); else n_pass++;
        n_total++;
        if (d4_acc_q !== 16'h0 || d4_cmd_ready !== 1'b1)
            $display("FAIL s4_reset_state got acc=%h rdy=%b exp acc=0000 rdy=1", d4_acc_q, d4_cmd_ready);
        else n_pass++;
        n_total++;
        if (d1_acc_q !== m_acc) $display("FAIL s4_reset_d1_acc got=%h exp=%h", d1_acc_q, m_acc); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_acc_chain();
        test_backpressure();
        test_random();
        test_settle4();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Overall time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
